// File: rtl/sequence_generator.sv
// Serial bit-pattern transmitter: captures pattern/len_m1 on load, then emits one bit per step on X.
// Optional continuous looping is enabled by defining SEQ_GEN_REPEAT_EN (adds the repeat_en port).
module sequence_generator #(
  parameter int PAT_W = 16,
  parameter int IDX_W = 4
) (
  input  logic             clk100mhz,
  input  logic             reset,
  input  logic             step,
  input  logic             load,
  input  logic [PAT_W-1:0] pattern,
  input  logic [IDX_W-1:0] len_m1,
`ifdef SEQ_GEN_REPEAT_EN
  input  logic             repeat_en,
`endif
  output logic             X,
  output logic             X_valid,
  output logic             busy,
  output logic             done,
  output logic [IDX_W-1:0] Q
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SEND = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t             state_reg;
  state_t             state_next;
  logic [PAT_W-1:0]   shreg_reg;
  logic [IDX_W-1:0]   cnt_reg;
  logic [IDX_W-1:0]   q_reg;
  logic               done_reg;
  logic               load_go;
  logic               last_step;
  logic               wrap;

  assign load_go   = load && (state_reg != S_SEND);
  assign last_step = (state_reg == S_SEND) && step && (q_reg == cnt_reg);

`ifdef SEQ_GEN_REPEAT_EN
  logic [PAT_W-1:0]   pat_q;
  assign wrap = last_step && repeat_en;
`else
  assign wrap = 1'b0;
`endif

  always_ff @(posedge clk100mhz or negedge reset) begin
    if (!reset) state_reg <= S_IDLE;
    else        state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_IDLE, S_DONE: if (load) state_next = S_SEND;
      S_SEND:         if (last_step && !wrap) state_next = S_DONE;
      default:        state_next = S_IDLE;
    endcase
  end

  // Since PAT_W == 2**IDX_W, ~len_m1 equals PAT_W-1-len_m1: the first bit lands on the MSB.
  always_ff @(posedge clk100mhz or negedge reset) begin
    if (!reset) begin
      shreg_reg <= '0;
      cnt_reg   <= '0;
      q_reg     <= '0;
      done_reg  <= 1'b0;
`ifdef SEQ_GEN_REPEAT_EN
      pat_q     <= '0;
`endif
    end else begin
      done_reg <= last_step;
      if (load_go) begin
        shreg_reg <= pattern << ~len_m1;
        cnt_reg   <= len_m1;
        q_reg     <= '0;
`ifdef SEQ_GEN_REPEAT_EN
        pat_q     <= pattern;
`endif
      end else if ((state_reg == S_SEND) && step) begin
        if (q_reg != cnt_reg) begin
          shreg_reg <= shreg_reg << 1;
          q_reg     <= q_reg + IDX_W'(1);
        end
`ifdef SEQ_GEN_REPEAT_EN
        else if (wrap) begin
          shreg_reg <= pat_q << ~cnt_reg;
          q_reg     <= '0;
        end
`endif
      end
    end
  end

  always_comb begin
    X       = (state_reg == S_SEND) && shreg_reg[PAT_W-1];
    X_valid = (state_reg == S_SEND);
    busy    = (state_reg == S_SEND);
    done    = done_reg;
    Q       = q_reg;
  end

endmodule
